// File: rtl/camo_gate_bank.sv
`default_nettype none
// ============================================================================
// Module      : camo_gate_bank
// Description : Bank of NUM_GATES camouflaged 2-input cells. A 2-bit key per
//               cell {s_1,s_0} selects its function (00 AND, 01 XOR, 10 NOR,
//               11 illegal, or NAND when CAMO_NAND_CELL_EN is defined). Keys
//               arrive serially into a shadow register, are legality-checked
//               for one cycle, then committed to the active key. Operands are
//               evaluated with registered, valid-qualified outputs.
// Optional    : `define CAMO_NAND_CELL_EN makes code 11 legal and select NAND.
// Ports       : clk, rst (sync, active-high)
//               load_start, key_bit, key_valid -> key_ready   (key load)
//               in_a, in_b, in_valid -> y, out_valid           (evaluation)
//               locked (legal key committed), key_err (last load illegal)
// Revision    : 1.0 - initial release
// ============================================================================
module camo_gate_bank #(
  parameter int NUM_GATES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 key_bit,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic [NUM_GATES-1:0] in_a,
  input  logic [NUM_GATES-1:0] in_b,
  input  logic                 in_valid,
  output logic [NUM_GATES-1:0] y,
  output logic                 out_valid,
  output logic                 locked,
  output logic                 key_err
);

  localparam int KEY_W = 2 * NUM_GATES;
  localparam int CNT_W = $clog2(KEY_W) + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  logic [2:0]           state_q,     state_d;
  logic [KEY_W-1:0]     shadow_q,    shadow_d;
  logic [KEY_W-1:0]     key_q,       key_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [NUM_GATES-1:0] y_q,         y_d;
  logic                 out_valid_q, out_valid_d;
  logic                 key_err_q,   key_err_d;

  logic [NUM_GATES-1:0] w_cell_y;
  logic [NUM_GATES-1:0] w_code_ok;

  // Code 11 evaluates as XOR in the default build, matching the MUX2
  // structure of the camouflaged netlist cell; CHECK keeps it from ever
  // being committed.
  function automatic logic cell_eval(input logic [1:0] code,
                                     input logic a, input logic b);
    case (code)
      2'b00:   cell_eval = a & b;
      2'b01:   cell_eval = a ^ b;
      2'b10:   cell_eval = ~(a | b);
`ifdef CAMO_NAND_CELL_EN
      default: cell_eval = ~(a & b);
`else
      default: cell_eval = a ^ b;
`endif
    endcase
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_GATES; gi++) begin : g_cell
      assign w_cell_y[gi] = cell_eval(key_q[2*gi+1:2*gi], in_a[gi], in_b[gi]);
`ifdef CAMO_NAND_CELL_EN
      assign w_code_ok[gi] = 1'b1;
`else
      assign w_code_ok[gi] = ~(&shadow_q[2*gi+1:2*gi]);
`endif
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    key_d       = key_q;
    cnt_d       = cnt_q;
    y_d         = y_q;
    out_valid_d = 1'b0;
    key_err_d   = key_err_q;

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end

      S_LOAD: begin
        // A restart takes priority over a bit offered in the same cycle.
        if (load_start) begin
          cnt_d = '0;
        end else if (key_valid) begin
          shadow_d = {key_bit, shadow_q[KEY_W-1:1]};
          cnt_d    = cnt_q + C_CNT_ONE;
          if (cnt_q == C_CNT_LAST) begin
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        if (&w_code_ok) begin
          key_d     = shadow_q;
          key_err_d = 1'b0;
          state_d   = S_ACTIVE;
        end else begin
          key_err_d = 1'b1;
          state_d   = S_ERROR;
        end
      end

      S_ACTIVE: begin
        // A reload takes priority over an evaluation in the same cycle.
        if (load_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else if (in_valid) begin
          y_d         = w_cell_y;
          out_valid_d = 1'b1;
        end
      end

      S_ERROR: begin
        if (load_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      key_q       <= '0;
      cnt_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      key_q       <= key_d;
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      key_err_q   <= key_err_d;
    end
  end

  assign key_ready = (state_q == S_LOAD);
  assign locked    = (state_q == S_ACTIVE);
  assign y         = y_q;
  assign out_valid = out_valid_q;
  assign key_err   = key_err_q;

endmodule
`default_nettype wire

// File: tb/tb_camo_gate_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_camo_gate_bank
// Description : Directed self-checking bench for camo_gate_bank with
//               NUM_GATES=2. Inputs change 1 time unit after the rising edge,
//               outputs are checked at that same point, i.e. after the edge
//               has settled. Key bit vectors are listed first-bit-first in
//               bit 0. Honours CAMO_NAND_CELL_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_camo_gate_bank;

  localparam int NUM_GATES = 2;

  logic                 clk;
  logic                 rst;
  logic                 load_start;
  logic                 key_bit;
  logic                 key_valid;
  logic                 key_ready;
  logic [NUM_GATES-1:0] in_a;
  logic [NUM_GATES-1:0] in_b;
  logic                 in_valid;
  logic [NUM_GATES-1:0] y;
  logic                 out_valid;
  logic                 locked;
  logic                 key_err;

  int checks;
  int errors;

  camo_gate_bank #(.NUM_GATES(NUM_GATES)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .key_bit    (key_bit),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_valid   (in_valid),
    .y          (y),
    .out_valid  (out_valid),
    .locked     (locked),
    .key_err    (key_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a load, shift four bits contiguously, leave the DUT in CHECK.
  task automatic load_key(input logic [3:0] bits);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      key_valid = 1'b1;
      key_bit   = bits[i];
      tick();
    end
    key_valid = 1'b0;
    key_bit   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_start = 1'b0; key_bit = 1'b0; key_valid = 1'b0;
    in_a = '0; in_b = '0; in_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({y, out_valid, key_ready, locked, key_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got y=%b ov=%b kr=%b lk=%b ke=%b expected all 0",
               y, out_valid, key_ready, locked, key_err);
    end
  endtask

  // cell0=00 AND, cell1=01 XOR: bits 0,0,1,0.
  task automatic test_and_xor();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checks++;
    if (key_ready !== 1'b1) begin
      errors++; $display("FAIL load_key_ready got %b expected 1", key_ready);
    end
    // operands offered while loading must be ignored
    in_valid = 1'b1; in_a = 2'b11; in_b = 2'b11;
    for (int i = 0; i < 4; i++) begin
      key_valid = 1'b1;
      key_bit   = (i == 2);
      tick();
    end
    key_valid = 1'b0;
    checks++;
    if (key_ready !== 1'b0 || out_valid !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL check_state got kr=%b ov=%b lk=%b expected 0 0 0",
               key_ready, out_valid, locked);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (locked !== 1'b1 || key_err !== 1'b0) begin
      errors++; $display("FAIL and_xor_commit got lk=%b ke=%b expected 1 0", locked, key_err);
    end
    in_a = 2'b11; in_b = 2'b01; in_valid = 1'b1;
    tick();
    checks++;
    if (y !== 2'b11 || out_valid !== 1'b1) begin
      errors++; $display("FAIL and_xor_eval got y=%b ov=%b expected 11 1", y, out_valid);
    end
    // back-to-back: AND(1,0)=0, XOR(0,1)=1
    in_a = 2'b01; in_b = 2'b10;
    tick();
    checks++;
    if (y !== 2'b10 || out_valid !== 1'b1) begin
      errors++; $display("FAIL back_to_back got y=%b ov=%b expected 10 1", y, out_valid);
    end
    in_valid = 1'b0; in_a = 2'b11; in_b = 2'b11;
    tick();
    checks++;
    if (y !== 2'b10 || out_valid !== 1'b0) begin
      errors++; $display("FAIL idle_hold got y=%b ov=%b expected 10 0", y, out_valid);
    end
  endtask

  // cell0=10 NOR, cell1=10 NOR: bits 0,1,0,1.
  task automatic test_nor();
    load_key(4'b1010);
    tick();
    checks++;
    if (locked !== 1'b1 || key_err !== 1'b0) begin
      errors++; $display("FAIL nor_commit got lk=%b ke=%b expected 1 0", locked, key_err);
    end
    in_a = 2'b00; in_b = 2'b00; in_valid = 1'b1;
    tick();
    checks++;
    if (y !== 2'b11 || out_valid !== 1'b1) begin
      errors++; $display("FAIL nor_zero got y=%b ov=%b expected 11 1", y, out_valid);
    end
    in_a = 2'b01;
    tick();
    checks++;
    if (y !== 2'b10 || out_valid !== 1'b1) begin
      errors++; $display("FAIL nor_a01 got y=%b ov=%b expected 10 1", y, out_valid);
    end
    in_valid = 1'b0;
  endtask

  // cell0=00, cell1=11: bits 0,0,1,1. Then recover with the AND/XOR key.
  task automatic test_illegal_key();
    load_key(4'b0100);
    tick();
    in_a = 2'b11; in_b = 2'b01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (y !== 2'b11 || out_valid !== 1'b1) begin
      errors++; $display("FAIL pre_err_eval got y=%b ov=%b expected 11 1", y, out_valid);
    end
    load_key(4'b1100);
    tick();
`ifdef CAMO_NAND_CELL_EN
    checks++;
    if (key_err !== 1'b0 || locked !== 1'b1) begin
      errors++; $display("FAIL code11_legal got ke=%b lk=%b expected 0 1", key_err, locked);
    end
`else
    checks++;
    if (key_err !== 1'b1 || locked !== 1'b0) begin
      errors++; $display("FAIL code11_error got ke=%b lk=%b expected 1 0", key_err, locked);
    end
    in_a = 2'b00; in_b = 2'b00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (y !== 2'b11 || out_valid !== 1'b0) begin
      errors++; $display("FAIL error_ignores_in got y=%b ov=%b expected 11 0", y, out_valid);
    end
    // key_err persists through the next load until CHECK
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checks++;
    if (key_err !== 1'b1 || key_ready !== 1'b1) begin
      errors++; $display("FAIL err_held_in_load got ke=%b kr=%b expected 1 1", key_err, key_ready);
    end
`endif
    load_key(4'b0100);
    tick();
    checks++;
    if (key_err !== 1'b0 || locked !== 1'b1) begin
      errors++; $display("FAIL recover_commit got ke=%b lk=%b expected 0 1", key_err, locked);
    end
    in_a = 2'b11; in_b = 2'b01; in_valid = 1'b1;
    tick();
    checks++;
    if (y !== 2'b11 || out_valid !== 1'b1) begin
      errors++; $display("FAIL recover_eval got y=%b ov=%b expected 11 1", y, out_valid);
    end
    // load_start with in_valid: load wins, no output, y holds
    in_a = 2'b00; in_b = 2'b00; load_start = 1'b1;
    tick();
    load_start = 1'b0; in_valid = 1'b0;
    checks++;
    if (y !== 2'b11 || out_valid !== 1'b0 || locked !== 1'b0 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_beats_eval got y=%b ov=%b lk=%b kr=%b expected 11 0 0 1",
               y, out_valid, locked, key_ready);
    end
  endtask

  task automatic test_reset_mid_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      key_valid = 1'b1; key_bit = 1'b1;
      tick();
    end
    key_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({y, out_valid, key_ready, locked, key_err} !== 6'b0) begin
      errors++;
      $display("FAIL mid_load_reset got y=%b ov=%b kr=%b lk=%b ke=%b expected all 0",
               y, out_valid, key_ready, locked, key_err);
    end
    for (int i = 0; i < 6; i++) begin
      key_valid = 1'b1; key_bit = 1'b1;
      tick();
      checks++;
      if (key_ready !== 1'b0 || locked !== 1'b0 || key_err !== 1'b0) begin
        errors++;
        $display("FAIL stray_bits_%0d got kr=%b lk=%b ke=%b expected 0 0 0",
                 i, key_ready, locked, key_err);
      end
    end
    key_valid = 1'b0;
  endtask

  task automatic test_gaps_and_restart();
    // AND/XOR key 0,0,1,0 with key_valid low on alternate cycles
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      key_valid = 1'b1; key_bit = (i == 2);
      tick();
      key_valid = 1'b0; key_bit = 1'b1;
      if (i < 3) begin
        tick();
        checks++;
        if (key_ready !== 1'b1) begin
          errors++; $display("FAIL gap_ready_%0d got %b expected 1", i, key_ready);
        end
      end
    end
    tick();
    in_a = 2'b11; in_b = 2'b01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (locked !== 1'b1 || y !== 2'b11 || out_valid !== 1'b1) begin
      errors++; $display("FAIL gap_key_eval got lk=%b y=%b ov=%b expected 1 11 1", locked, y, out_valid);
    end
    // restart on the 3rd bit; then NOR/NOR key 0,1,0,1 needs 4 more bits
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    key_valid = 1'b1; key_bit = 1'b1;
    tick(); tick();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      key_bit = (i == 1);
      tick();
    end
    checks++;
    if (key_ready !== 1'b1) begin
      errors++; $display("FAIL restart_3_bits got kr=%b expected 1", key_ready);
    end
    key_bit = 1'b1;
    tick();
    key_valid = 1'b0;
    checks++;
    if (key_ready !== 1'b0) begin
      errors++; $display("FAIL restart_4_bits got kr=%b expected 0", key_ready);
    end
    tick();
    in_a = 2'b00; in_b = 2'b00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (locked !== 1'b1 || y !== 2'b11 || out_valid !== 1'b1) begin
      errors++; $display("FAIL restart_key_eval got lk=%b y=%b ov=%b expected 1 11 1", locked, y, out_valid);
    end
    in_a = 2'b01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (y !== 2'b10) begin
      errors++; $display("FAIL restart_key_nor got y=%b expected 10", y);
    end
  endtask

  task automatic test_code11();
    // both cells 11: bits 1,1,1,1
    load_key(4'b1111);
    tick();
    in_a = 2'b11; in_b = 2'b10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
`ifdef CAMO_NAND_CELL_EN
    checks++;
    if (locked !== 1'b1 || y !== 2'b01 || out_valid !== 1'b1) begin
      errors++; $display("FAIL nand_eval got lk=%b y=%b ov=%b expected 1 01 1", locked, y, out_valid);
    end
`else
    // y still holds the last NOR result (10)
    checks++;
    if (locked !== 1'b0 || key_err !== 1'b1 || y !== 2'b10 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL all11_error got lk=%b ke=%b y=%b ov=%b expected 0 1 10 0",
               locked, key_err, y, out_valid);
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_and_xor();
    test_nor();
    test_illegal_key();
    test_reset_mid_load();
    test_gaps_and_restart();
    test_code11();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/camo_gate_bank.md
Name: camo_gate_bank

Overview:
- Parametrised bank of NUM_GATES camouflaged 2-input cells. Each cell's function is selected by a 2-bit key {s_1,s_0}.
- This is the sequential successor to the single MUX2-camouflaged gate used in the c17 de-camouflaging examples.
- Keys are loaded serially, legality-checked against the allowed set (00,01,10), then committed. Gate outputs are then evaluated with registered, valid-qualified outputs.
- Sits between key-delivery logic and the combinational netlist under test, so the SAT oracle can reconfigure cells without re-synthesis.

Parameters:
- NUM_GATES, 4, number of camouflaged cells; legal range 1..64.
- KEY_W, 2*NUM_GATES, total key bits; derived, not overridden.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst  input  1  synchronous active-high reset.
- load_start  input  1  pulse: begin a new serial key load.
- key_bit  input  1  serial key data.
- key_valid  input  1  key_bit valid this cycle.
- key_ready  output  1  bank accepts key_bit this cycle.
- in_a  input  NUM_GATES  operand a, bit i feeds cell i.
- in_b  input  NUM_GATES  operand b, bit i feeds cell i.
- in_valid  input  1  operands valid.
- y  output  NUM_GATES  registered cell outputs.
- out_valid  output  1  y valid.
- locked  output  1  a legal key is committed (state ACTIVE).
- key_err  output  1  last completed load contained an illegal code.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; shadow key, active key, bit counter = 0; y=0, out_valid=0, key_ready=0, locked=0, key_err=0. Reset overrides every other input, including mid-load.
- States: IDLE, LOAD, CHECK, ACTIVE, ERROR.
- IDLE: key_ready=0. load_start -> LOAD; counter cleared.
- LOAD: key_ready=1.
  - Bit accepted when key_valid=1: shadow shifts right, key_bit enters the MSB, counter increments.
  - After KEY_W accepted bits, the first bit received sits at shadow[0]. Cell i uses shadow[2i+1:2i] = {s_1,s_0}.
  - The acceptance of bit KEY_W-1 -> CHECK.
  - load_start in LOAD restarts: counter=0; shadow contents are don't-care.
- CHECK (1 cycle, key_ready=0):
  - All cell codes legal -> copy shadow to active key, key_err=0, -> ACTIVE.
  - Otherwise -> active key unchanged, key_err=1, -> ERROR.
- ACTIVE: locked=1.
  - in_valid=1 at edge N -> y[i] = f(key_i, in_a[i], in_b[i]) and out_valid=1 at edge N+1. Latency 1, full throughput.
  - in_valid=0 -> out_valid=0 next cycle; y holds its last value.
  - load_start -> LOAD, locked=0.
- ERROR: locked=0, key_err held. load_start -> LOAD; key_err stays 1 until the next CHECK.
- Cell function:
  - 00 = AND.
  - 01 = XOR.
  - 10 = NOR.
  - 11 = illegal; XOR if it is ever evaluated (equal to the netlist MUX2 structure), but it is never committed.
- Outside ACTIVE: in_valid ignored, out_valid=0, y holds its last value.
- Simultaneous events: load_start together with key_valid in LOAD -> restart wins, bit discarded. load_start together with in_valid in ACTIVE -> load wins, no output produced.
- Counter width is clog2(KEY_W)+1; no wrap, since CHECK is entered exactly at KEY_W.

Optional Feature:
- CAMO_NAND_CELL_EN defined: code 11 is legal and selects NAND; CHECK never flags it.
- CAMO_NAND_CELL_EN undefined: code 11 is illegal, as described above. Default is undefined.

Test Plan:
1. NUM_GATES=2: reset, then load bits 0,0,1,0 (cell0=00 AND, cell1=01 XOR) -> CHECK then locked=1, key_err=0. Then in_a=2'b11, in_b=2'b01, in_valid=1 -> next cycle y=2'b11, out_valid=1.
2. NUM_GATES=2: load cell0=10 (NOR), cell1=10 -> with in_a=0, in_b=0 -> y=2'b11; with in_a=2'b01, in_b=0 -> y=2'b10.
3. While ACTIVE with an AND/XOR key, load cell1=11 -> key_err=1, locked=0. Issue a second load_start with the legal AND/XOR key -> ACTIVE, and test-1 vectors reproduce y=2'b11.
4. Pulse rst after 3 of 4 key bits -> next cycle all outputs 0 and state IDLE. A key_valid burst without load_start -> key_ready stays 0 and nothing is accepted.
5. Drop key_valid on alternate cycles during a load -> same committed key as a contiguous load. Assert load_start on the 3rd bit -> counter restarts; 4 further bits are required to reach CHECK.
6. With CAMO_NAND_CELL_EN defined: load code 11 for both cells -> locked=1; in_a=2'b11, in_b=2'b10 -> y=2'b01.
